// File: rtl/seven_seg_scan_if.sv
// Scanned display lines (driven by the display side) and the decoded frame outputs.
interface seven_seg_scan_if;
  logic [6:0]  segments;
  logic [3:0]  anode_active;
  logic        decimal_pt;
  logic [15:0] digits;
  logic [3:0]  dp_mask;
  logic        frame_valid;
  logic        frame_done;
  logic        digits_changed;
  logic        decode_err;

  modport master (
    output segments, anode_active, decimal_pt,
    input  digits, dp_mask, frame_valid, frame_done, digits_changed, decode_err
  );

  modport slave (
    input  segments, anode_active, decimal_pt,
    output digits, dp_mask, frame_valid, frame_done, digits_changed, decode_err
  );
endinterface

// File: rtl/seven_seg_scan_decoder.sv
// Snoops a multiplexed active-low seven-segment display, waits for each digit slot
// to settle, decodes it back to BCD and publishes coherent 4-digit frames.
module seven_seg_scan_decoder #(
  parameter int unsigned STABLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 4_000_000
) (
  input  logic            clk,
  input  logic            rst,
  seven_seg_scan_if.slave scan
);
  localparam int unsigned     SW          = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned     TW          = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SW-1:0]   STABLE_MAX  = SW'(STABLE_CYCLES);
  localparam logic [TW-1:0]   TIMEOUT_MAX = TW'(TIMEOUT_CYCLES);
  // Sample word is {anode[3:0], segments[6:0], dp}; all-ones is a dark, idle display.
  localparam logic [11:0]     IDLE_SAMPLE = 12'hFFF;

  logic [11:0]   sync1_q, sync2_q, prev_q;
  logic [SW-1:0] stab_q, stab_d;
  logic [15:0]   shadow_q, shadow_d;
  logic [3:0]    shadow_dp_q, shadow_dp_d;
  logic [3:0]    seen_q, seen_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [15:0]   digits_q;
  logic [3:0]    dp_mask_q;
  logic          frame_valid_q, frame_done_q, changed_q, err_q;

  logic [3:0] anode;
  logic [6:0] seg;
  logic       dp_n;
  logic [1:0] slot;
  logic       slot_valid, anode_err, same, capture, publish, expire;
  logic [3:0] nib;
  logic       seg_ok;

  assign {anode, seg, dp_n} = sync2_q;

  always_comb begin
    slot       = 2'd0;
    slot_valid = 1'b1;
    case (anode)
      4'b0111: slot = 2'd3;
      4'b1011: slot = 2'd2;
      4'b1101: slot = 2'd1;
      4'b1110: slot = 2'd0;
      default: slot_valid = 1'b0;
    endcase
  end

  always_comb begin
    nib    = 4'hF;
    seg_ok = 1'b1;
    case (seg)
      7'h01:   nib = 4'd0;
      7'h4F:   nib = 4'd1;
      7'h12:   nib = 4'd2;
      7'h06:   nib = 4'd3;
      7'h4C:   nib = 4'd4;
      7'h24:   nib = 4'd5;
      7'h20:   nib = 4'd6;
      7'h0F:   nib = 4'd7;
      7'h00:   nib = 4'd8;
      7'h04:   nib = 4'd9;
      default: seg_ok = 1'b0;
    endcase
  end

  // Illegal anode patterns flag only on the cycle they first appear.
  assign anode_err = !slot_valid && (anode != 4'b1111) && (anode != prev_q[11:8]);
  assign same      = (sync2_q == prev_q);
  assign capture   = same && slot_valid && (stab_q == STABLE_MAX - 1'b1);
  assign publish   = (seen_q == 4'hF);
  assign expire    = !publish && (tmo_q == TIMEOUT_MAX - 1'b1);

  always_comb begin
    stab_d      = stab_q;
    seen_d      = seen_q;
    shadow_d    = shadow_q;
    shadow_dp_d = shadow_dp_q;
    tmo_d       = tmo_q;
    if (!same)
      stab_d = SW'(1);
    else if (stab_q != STABLE_MAX)
      stab_d = stab_q + 1'b1;
    if (publish || expire)
      seen_d = 4'h0;
    if (capture) begin
      seen_d[slot]                 = 1'b1;
      shadow_d[{slot, 2'b00} +: 4] = nib;
      shadow_dp_d[slot]            = ~dp_n;
    end
    if (publish)
      tmo_d = '0;
    else if (tmo_q != TIMEOUT_MAX)
      tmo_d = tmo_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q       <= IDLE_SAMPLE;
      sync2_q       <= IDLE_SAMPLE;
      prev_q        <= IDLE_SAMPLE;
      stab_q        <= '0;
      shadow_q      <= '0;
      shadow_dp_q   <= '0;
      seen_q        <= '0;
      tmo_q         <= '0;
      digits_q      <= '0;
      dp_mask_q     <= '0;
      frame_valid_q <= 1'b0;
      frame_done_q  <= 1'b0;
      changed_q     <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      sync1_q       <= {scan.anode_active, scan.segments, scan.decimal_pt};
      sync2_q       <= sync1_q;
      prev_q        <= sync2_q;
      stab_q        <= stab_d;
      shadow_q      <= shadow_d;
      shadow_dp_q   <= shadow_dp_d;
      seen_q        <= seen_d;
      tmo_q         <= tmo_d;
      frame_done_q  <= publish;
      changed_q     <= publish && (shadow_q != digits_q);
      err_q         <= anode_err || (capture && !seg_ok);
      if (publish) begin
        digits_q      <= shadow_q;
        dp_mask_q     <= shadow_dp_q;
        frame_valid_q <= 1'b1;
      end else if (expire) begin
        frame_valid_q <= 1'b0;
      end
    end
  end

  assign scan.digits         = digits_q;
  assign scan.dp_mask        = dp_mask_q;
  assign scan.frame_valid    = frame_valid_q;
  assign scan.frame_done     = frame_done_q;
  assign scan.digits_changed = changed_q;
  assign scan.decode_err     = err_q;
endmodule

// File: tb/tb_seven_seg_scan_decoder.sv
// Bench for seven_seg_scan_decoder: directed frame table, randomized scans against a
// dwell-level reference model, timeout and mid-frame reset sequences.
module tb_seven_seg_scan_decoder;
  localparam int STABLE = 4;
  localparam int TMO    = 100;
  localparam int DWELL  = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seven_seg_scan_if scan ();

  seven_seg_scan_decoder #(.STABLE_CYCLES(STABLE), .TIMEOUT_CYCLES(TMO)) dut (
    .clk  (clk),
    .rst  (rst),
    .scan (scan)
  );

  // ---------------- monitor (sole writer of the obs_* record) ----------------
  int          cyc = 0;
  int          obs_cnt = 0;
  int          err_seen = 0;
  int          viol_cnt = 0;
  logic [15:0] obs_dig [64];
  logic [3:0]  obs_dp  [64];
  logic        obs_chg [64];
  int          obs_cyc [64];
  logic [15:0] mon_prev_dig = '0;
  logic [3:0]  mon_prev_dp = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (scan.decode_err === 1'b1) err_seen <= err_seen + 1;
      if (scan.frame_done === 1'b1) begin
        if (obs_cnt < 64) begin
          obs_dig[obs_cnt] <= scan.digits;
          obs_dp[obs_cnt]  <= scan.dp_mask;
          obs_chg[obs_cnt] <= scan.digits_changed;
          obs_cyc[obs_cnt] <= cyc;
        end
        obs_cnt <= obs_cnt + 1;
      end else if (scan.digits_changed !== 1'b0 || scan.digits !== mon_prev_dig ||
                   scan.dp_mask !== mon_prev_dp) begin
        viol_cnt <= viol_cnt + 1;
      end
    end
    mon_prev_dig <= scan.digits;
    mon_prev_dp  <= scan.dp_mask;
  end

  // ---------------- reference model: one call per settled dwell ----------------
  logic [6:0]  SEG_TAB [10] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F, 7'h00, 7'h04};
  logic [3:0]  m_sh [4];
  logic        m_dp [4];
  logic        m_seen [4];
  logic [15:0] m_prev;
  logic [15:0] exp_dig [64];
  logic [3:0]  exp_dp  [64];
  logic        exp_chg [64];
  int          exp_cnt = 0;
  int          exp_err = 0;

  function automatic logic [3:0] decode_ref(input logic [6:0] code);
    logic [3:0] r;
    r = 4'hF;
    for (int d = 0; d < 10; d++)
      if (SEG_TAB[d] == code) r = 4'(d);
    return r;
  endfunction

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    return (d < 4'd10) ? SEG_TAB[d] : 7'h7F;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 4; s++) begin
      m_sh[s] = 4'h0; m_dp[s] = 1'b0; m_seen[s] = 1'b0;
    end
    m_prev = 16'h0000;
  endtask

  task automatic model_capture(input int slot, input logic [6:0] code, input logic dp);
    logic [15:0] fr;
    logic [3:0]  dm;
    m_sh[slot]   = decode_ref(code);
    m_dp[slot]   = dp;
    m_seen[slot] = 1'b1;
    if (m_sh[slot] == 4'hF) exp_err++;
    if (m_seen[0] && m_seen[1] && m_seen[2] && m_seen[3]) begin
      fr = {m_sh[3], m_sh[2], m_sh[1], m_sh[0]};
      dm = {m_dp[3], m_dp[2], m_dp[1], m_dp[0]};
      exp_dig[exp_cnt] = fr;
      exp_dp[exp_cnt]  = dm;
      exp_chg[exp_cnt] = (fr != m_prev);
      m_prev = fr;
      exp_cnt++;
      for (int s = 0; s < 4; s++) m_seen[s] = 1'b0;
    end
  endtask

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_digits"}, 32'(scan.digits), 32'h0);
    check({tag, "_dp"}, 32'(scan.dp_mask), 32'h0);
    check({tag, "_valid"}, 32'(scan.frame_valid), 32'h0);
    check({tag, "_done"}, 32'(scan.frame_done), 32'h0);
    check({tag, "_changed"}, 32'(scan.digits_changed), 32'h0);
    check({tag, "_err"}, 32'(scan.decode_err), 32'h0);
  endtask

  // ---------------- stimulus ----------------
  task automatic drive(input logic [3:0] an, input logic [6:0] seg, input logic dp_n, input int n);
    scan.anode_active = an;
    scan.segments     = seg;
    scan.decimal_pt   = dp_n;
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [3:0] anode_of(input int slot);
    logic [3:0] a;
    a = 4'b0001 << slot;
    return ~a;
  endfunction

  task automatic dwell(input int slot, input logic [6:0] code, input logic dp, input int n);
    drive(anode_of(slot), code, ~dp, n);
    if (n >= STABLE) model_capture(slot, code, dp);
  endtask

  task automatic glitch_anode();
    drive(4'b0011, 7'h7F, 1'b1, 2);
    exp_err++;
  endtask

  task automatic glitch_code(input int slot);
    drive(anode_of(slot), 7'h7F, 1'b1, 2);
  endtask

  task automatic scan_frame(input logic [15:0] bcd, input logic [3:0] dp, input logic glitch, input int n);
    for (int s = 3; s >= 0; s--) begin
      if (glitch && (s == 2 || s == 0)) glitch_anode();
      if (glitch && s == 1) glitch_code(s);
      dwell(s, seg_of(bcd[s*4 +: 4]), dp[s], n);
    end
  endtask

  typedef struct {
    logic [15:0] bcd;
    logic [3:0]  dp;
    logic        glitch;
    logic [15:0] exp_dig;
    logic [3:0]  exp_dp;
    logic        exp_chg;
    int          exp_errs;
  } vec_t;

  vec_t vecs [5];
  int   f0, k0, e0, ee0, last, t, oi;
  logic [3:0] rd;

  initial begin
    vecs[0] = '{16'h1234, 4'b0100, 1'b0, 16'h1234, 4'b0100, 1'b1, 0};
    vecs[1] = '{16'h1234, 4'b0100, 1'b0, 16'h1234, 4'b0100, 1'b0, 0};
    vecs[2] = '{16'h1234, 4'b0100, 1'b1, 16'h1234, 4'b0100, 1'b0, 2};
    vecs[3] = '{16'h1235, 4'b0100, 1'b0, 16'h1235, 4'b0100, 1'b1, 0};
    vecs[4] = '{16'h12F4, 4'b0100, 1'b0, 16'h12F4, 4'b0100, 1'b1, 1};

    scan.anode_active = 4'hF;
    scan.segments     = 7'h7F;
    scan.decimal_pt   = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      f0 = obs_cnt;
      e0 = err_seen;
      scan_frame(vecs[i].bcd, vecs[i].dp, vecs[i].glitch, DWELL);
      #1;
      last = (obs_cnt > 0) ? obs_cnt - 1 : 0;
      check($sformatf("vec%0d_frames", i), obs_cnt - f0, 1);
      check($sformatf("vec%0d_digits", i), 32'(obs_dig[last]), 32'(vecs[i].exp_dig));
      check($sformatf("vec%0d_dp", i), 32'(obs_dp[last]), 32'(vecs[i].exp_dp));
      check($sformatf("vec%0d_changed", i), 32'(obs_chg[last]), 32'(vecs[i].exp_chg));
      check($sformatf("vec%0d_errs", i), err_seen - e0, vecs[i].exp_errs);
      check($sformatf("vec%0d_valid", i), 32'(scan.frame_valid), 32'h1);
    end

    f0 = obs_cnt; k0 = exp_cnt; e0 = err_seen; ee0 = exp_err;
    for (int f = 0; f < 20; f++) begin
      for (int s = 3; s >= 0; s--) begin
        case ($urandom_range(0, 3))
          1: drive(4'hF, 7'h7F, 1'b1, int'($urandom_range(1, 4)));
          2: glitch_anode();
          3: glitch_code(s);
          default: ;
        endcase
        rd = ($urandom_range(0, 15) == 0) ? 4'hF : 4'($urandom_range(0, 9));
        dwell(s, seg_of(rd), 1'($urandom_range(0, 1)), int'($urandom_range(6, 16)));
      end
    end
    repeat (10) @(negedge clk);
    #1;
    check("rand_frames", obs_cnt - f0, exp_cnt - k0);
    for (int i = k0; i < exp_cnt; i++) begin
      oi = f0 + (i - k0);
      check($sformatf("rand%0d_digits", i - k0), 32'(obs_dig[oi]), 32'(exp_dig[i]));
      check($sformatf("rand%0d_dp", i - k0), 32'(obs_dp[oi]), 32'(exp_dp[i]));
      check($sformatf("rand%0d_changed", i - k0), 32'(obs_chg[oi]), 32'(exp_chg[i]));
    end
    check("rand_errs", err_seen - e0, exp_err - ee0);

    drive(4'hF, 7'h7F, 1'b1, 0);
    check("tmo_valid_before", 32'(scan.frame_valid), 32'h1);
    t = 0;
    while (scan.frame_valid === 1'b1 && t < 300) begin
      @(negedge clk);
      t++;
    end
    last = (obs_cnt > 0) ? obs_cnt - 1 : 0;
    check("tmo_latency", cyc - obs_cyc[last], TMO);
    repeat (20) @(negedge clk);
    #1;
    check("tmo_valid_after", 32'(scan.frame_valid), 32'h0);
    check("tmo_digits_held", 32'(scan.digits), 32'(exp_dig[exp_cnt-1]));
    check("tmo_dp_held", 32'(scan.dp_mask), 32'(exp_dp[exp_cnt-1]));
    for (int s = 0; s < 4; s++) m_seen[s] = 1'b0;
    f0 = obs_cnt;
    scan_frame(16'h5678, 4'b0001, 1'b0, DWELL);
    #1;
    last = (obs_cnt > 0) ? obs_cnt - 1 : 0;
    check("recover_frames", obs_cnt - f0, 1);
    check("recover_digits", 32'(obs_dig[last]), 32'h5678);
    check("recover_dp", 32'(obs_dp[last]), 32'h1);
    check("recover_changed", 32'(obs_chg[last]), 32'(exp_chg[exp_cnt-1]));
    check("recover_valid", 32'(scan.frame_valid), 32'h1);

    dwell(3, seg_of(4'd7), 1'b0, DWELL);
    dwell(2, seg_of(4'd8), 1'b1, DWELL);
    rst = 1'b1;
    #1;
    check_zero("midreset");
    scan.anode_active = 4'hF;
    scan.segments     = 7'h7F;
    scan.decimal_pt   = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
    f0 = obs_cnt;
    e0 = err_seen;
    scan_frame(16'h0930, 4'b0000, 1'b0, DWELL);
    #1;
    last = (obs_cnt > 0) ? obs_cnt - 1 : 0;
    check("postreset_frames", obs_cnt - f0, 1);
    check("postreset_digits", 32'(obs_dig[last]), 32'h0930);
    check("postreset_dp", 32'(obs_dp[last]), 32'h0);
    check("postreset_changed", 32'(obs_chg[last]), 32'h1);
    check("postreset_valid", 32'(scan.frame_valid), 32'h1);
    check("postreset_errs", err_seen - e0, 0);
    check("no_stray_output_change", viol_cnt, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
